seq_controller: RTL and testbench

Parametrised multi-cycle instruction sequencer for the ARM32 core; successor to the fixed-latency controller FSM. Adds configurable fetch/memory latency with a RAM ready handshake, ARM condition-code evaluation, a sticky halt state, status-flag update for CMP, and base-register writeback for LDR/STR. Sits between the instruction register/decoder and the datapath, regfile, PC and RAM control inputs.

---
 rtl/seq_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_seq_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle ARM32 instruction sequencer with configurable
// fetch/memory latency, condition-code evaluation, sticky halt and
// load/store base writeback control.
module seq_controller #(
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  input  logic       P,
  input  logic       U,
  input  logic       W,
  input  logic       ram_ready,
  output logic [3:0] state,
  output logic       waiting,
  output logic       halted,
  output logic       cond_pass,
  output logic       clear_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       en_A,
  output logic       en_B,
  output logic       en_S,
  output logic       en_C,
  output logic       en_status,
  output logic [1:0] sel_A_in,
  output logic [1:0] sel_shift_in,
  output logic       sel_A,
  output logic       sel_B,
  output logic       sel_shift,
  output logic       sel_post_shift,
  output logic [2:0] ALU_op,
  output logic       w_en1,
  output logic       w_en2,
  output logic       sel_w_data,
  output logic       ram_w_en2
);

  localparam logic [3:0] S_RESET       = 4'd0;
  localparam logic [3:0] S_LOAD_PC     = 4'd1;
  localparam logic [3:0] S_FETCH       = 4'd2;
  localparam logic [3:0] S_FETCH_WAIT  = 4'd3;
  localparam logic [3:0] S_DECODE      = 4'd4;
  localparam logic [3:0] S_EXECUTE     = 4'd5;
  localparam logic [3:0] S_MEMORY      = 4'd6;
  localparam logic [3:0] S_MEMORY_WAIT = 4'd7;
  localparam logic [3:0] S_WRITE_BACK  = 4'd8;
  localparam logic [3:0] S_HALT        = 4'd9;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec_q, exec_d;

  logic n_f, z_f, c_f, v_f;
  logic is_nop, is_hlt, is_alu, is_ls, is_cmp;
  logic f_done, m_done;
  logic [CNT_W-1:0] cnt_sat;

  assign {n_f, z_f, c_f, v_f} = nzcv;

  // ARM condition-code evaluation against the current flags
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end

  // NOP and HLT live in the ALU opcode space but must not drive the datapath
  assign is_nop  = (opcode == 7'b0000000);
  assign is_hlt  = (opcode == 7'b0000001);
  assign is_alu  = !opcode[6] && (cond != 4'b1111) && !is_nop && !is_hlt;
  assign is_ls   = (opcode[6:5] == 2'b11) || (opcode[6:3] == 4'b1001);
  assign is_cmp  = is_alu && (opcode[3:0] == 4'b1010);

  assign cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign f_done  = (cnt_q >= CNT_W'(FETCH_LAT - 1)) && ram_ready;
  assign m_done  = (cnt_q >= CNT_W'(MEM_LAT - 1)) && ram_ready;

  // State, wait counter and executed-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exec_q  <= exec_d;
    end
  end

  // Next-state, wait-count and executed-flag logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    exec_d  = exec_q;
    case (state_q)
      S_RESET:      state_d = S_LOAD_PC;
      S_LOAD_PC:    state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (f_done) state_d = S_DECODE;
        else        cnt_d   = cnt_sat;
      end
      S_DECODE:     state_d = S_EXECUTE;
      S_EXECUTE: begin
        exec_d = cond_pass;
        if (!cond_pass)  state_d = S_WRITE_BACK;
        else if (is_hlt) state_d = S_HALT;
        else             state_d = S_MEMORY;
      end
      S_MEMORY:      state_d = S_MEMORY_WAIT;
      S_MEMORY_WAIT: begin
        if (m_done) state_d = S_WRITE_BACK;
        else        cnt_d   = cnt_sat;
      end
      S_WRITE_BACK:  state_d = S_FETCH;
      S_HALT:        state_d = S_HALT;
      default:       state_d = S_RESET;
    endcase
  end

  // Decoded control outputs from state, instruction class and flags
  always_comb begin
    waiting        = (state_q != S_HALT);
    halted         = 1'b0;
    clear_pc       = 1'b0;
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    en_C           = 1'b0;
    en_status      = 1'b0;
    sel_A_in       = 2'b00;
    sel_shift_in   = 2'b00;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_shift      = 1'b0;
    sel_post_shift = 1'b0;
    ALU_op         = OP_ADD;
    w_en1          = 1'b0;
    w_en2          = 1'b0;
    sel_w_data     = 1'b0;
    ram_w_en2      = 1'b0;
    case (state_q)
      S_RESET:   clear_pc = 1'b1;
      S_LOAD_PC: load_pc  = 1'b1;
      S_DECODE:  load_ir  = 1'b1;
      S_EXECUTE: begin
        if (cond_pass && is_alu) begin
          en_A = opcode[3];
          en_B = opcode[4];
          en_S = 1'b1;
          if (opcode[4]) begin
            sel_shift = opcode[5];
          end else begin
            sel_shift    = 1'b1;
            sel_shift_in = 2'b11;
          end
        end else if (cond_pass && is_ls) begin
          en_A = 1'b1;
          en_S = 1'b1;
          sel_shift = 1'b1;
          if (!opcode[3]) begin
            sel_shift_in = 2'b11;
            if (opcode[6:4] == 3'b100) sel_A_in = 2'b11;
          end else begin
            en_B = 1'b1;
          end
        end
      end
      S_MEMORY: begin
        if (is_alu) begin
          en_C  = 1'b1;
          sel_A = !opcode[3];
          sel_B = !opcode[4];
          en_status = (opcode[3:0] == 4'b1010);
          case (opcode[2:0])
            3'b000:  ALU_op = OP_ADD;
            3'b001:  ALU_op = OP_SUB;
            3'b010:  ALU_op = OP_SUB;
            3'b011:  ALU_op = OP_AND;
            3'b100:  ALU_op = OP_ORR;
            3'b101:  ALU_op = OP_XOR;
            default: ALU_op = OP_ADD;
          endcase
        end else if (is_ls) begin
          en_C           = 1'b1;
          ALU_op         = U ? OP_ADD : OP_SUB;
          sel_post_shift = opcode[3] && P;
          sel_B          = !(opcode[3] && P);
          ram_w_en2      = opcode[4];
        end
      end
      S_WRITE_BACK: begin
        load_pc = 1'b1;
        if (exec_q && is_alu) begin
          w_en1 = !is_cmp;
        end else if (exec_q && is_ls) begin
          w_en1      = !opcode[4];
          sel_w_data = !opcode[4];
          w_en2      = W || !P;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed and randomized instruction streams checked
// against an instruction-level reference model of the sequencer.
module tb_seq_controller;

  localparam int FL = 3;
  localparam int ML = 2;

  typedef struct packed {
    logic       waiting, halted, clear_pc, load_pc, load_ir;
    logic       en_A, en_B, en_S, en_C, en_status;
    logic [1:0] sel_A_in, sel_shift_in;
    logic       sel_A, sel_B, sel_shift, sel_post_shift;
    logic [2:0] ALU_op;
    logic       w_en1, w_en2, sel_w_data, ram_w_en2;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [3:0] cond = 4'b1110;
  logic [3:0] nzcv = '0;
  logic P = 1'b0, U = 1'b0, W = 1'b0, ram_ready = 1'b1;
  logic [3:0] state;
  logic waiting, halted, cond_pass, clear_pc, load_pc, load_ir;
  logic en_A, en_B, en_S, en_C, en_status;
  logic [1:0] sel_A_in, sel_shift_in;
  logic sel_A, sel_B, sel_shift, sel_post_shift;
  logic [2:0] ALU_op;
  logic w_en1, w_en2, sel_w_data, ram_w_en2;
  outs_t obs;

  int checks = 0;
  int errors = 0;

  seq_controller #(.FETCH_LAT(FL), .MEM_LAT(ML), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .nzcv(nzcv),
    .P(P), .U(U), .W(W), .ram_ready(ram_ready),
    .state(state), .waiting(waiting), .halted(halted), .cond_pass(cond_pass),
    .clear_pc(clear_pc), .load_pc(load_pc), .load_ir(load_ir),
    .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_C(en_C), .en_status(en_status),
    .sel_A_in(sel_A_in), .sel_shift_in(sel_shift_in), .sel_A(sel_A), .sel_B(sel_B),
    .sel_shift(sel_shift), .sel_post_shift(sel_post_shift), .ALU_op(ALU_op),
    .w_en1(w_en1), .w_en2(w_en2), .sel_w_data(sel_w_data), .ram_w_en2(ram_w_en2)
  );

  always #5 clk = ~clk;

  assign obs = {waiting, halted, clear_pc, load_pc, load_ir, en_A, en_B, en_S, en_C,
                en_status, sel_A_in, sel_shift_in, sel_A, sel_B, sel_shift,
                sel_post_shift, ALU_op, w_en1, w_en2, sel_w_data, ram_w_en2};

  // Condition table: even codes test a predicate, odd codes its negation
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.waiting = 1'b1;
    return o;
  endfunction

  function automatic logic alu_cls(input logic [6:0] op, input logic [3:0] c);
    return !op[6] && (c != 4'b1111) && (op > 7'd1);
  endfunction

  function automatic logic ls_cls(input logic [6:0] op);
    return (op[6:5] == 2'b11) || (op[6:3] == 4'b1001);
  endfunction

  function automatic outs_t exec_ref(input logic [6:0] op, input logic [3:0] c);
    outs_t o;
    o = idle();
    if (alu_cls(op, c)) begin
      o.en_A = op[3]; o.en_B = op[4]; o.en_S = 1'b1;
      o.sel_shift = op[4] ? op[5] : 1'b1;
      o.sel_shift_in = op[4] ? 2'b00 : 2'b11;
    end else if (ls_cls(op)) begin
      o.en_A = 1'b1; o.en_S = 1'b1; o.sel_shift = 1'b1;
      o.en_B = op[3];
      o.sel_shift_in = op[3] ? 2'b00 : 2'b11;
      o.sel_A_in = (!op[3] && op[6:4] == 3'b100) ? 2'b11 : 2'b00;
    end
    return o;
  endfunction

  function automatic outs_t mem_ref(input logic [6:0] op, input logic [3:0] c,
                                    input logic p, input logic u);
    outs_t o;
    logic [2:0] tab [8];
    tab = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b011, 3'b111, 3'b000, 3'b000};
    o = idle();
    if (alu_cls(op, c)) begin
      o.en_C = 1'b1;
      o.ALU_op = tab[op[2:0]];
      o.sel_A = ~op[3]; o.sel_B = ~op[4];
      o.en_status = (op[3:0] == 4'b1010);
    end else if (ls_cls(op)) begin
      o.en_C = 1'b1;
      o.ALU_op = u ? 3'b000 : 3'b001;
      o.sel_post_shift = op[3] & p;
      o.sel_B = ~(op[3] & p);
      o.ram_w_en2 = op[4];
    end
    return o;
  endfunction

  function automatic outs_t wb_ref(input logic [6:0] op, input logic [3:0] c,
                                   input logic p, input logic w, input logic ran);
    outs_t o;
    o = idle();
    o.load_pc = 1'b1;
    if (ran && alu_cls(op, c)) begin
      o.w_en1 = (op[3:0] != 4'b1010);
    end else if (ran && ls_cls(op)) begin
      o.w_en1 = ~op[4]; o.sel_w_data = ~op[4];
      o.w_en2 = w | ~p;
    end
    return o;
  endfunction

  task automatic check_cycle(input string tag, input logic [3:0] es, input outs_t eo,
                             input logic ecp);
    #1;
    checks++;
    assert (state === es) else begin
      errors++;
      $error("FAIL %s state observed %0d expected %0d", tag, state, es);
    end
    checks++;
    assert (obs === eo) else begin
      errors++;
      $error("FAIL %s outputs observed %h expected %h", tag, obs, eo);
    end
    checks++;
    assert (cond_pass === ecp) else begin
      errors++;
      $error("FAIL %s cond_pass observed %b expected %b", tag, cond_pass, ecp);
    end
    @(posedge clk);
    #1;
  endtask

  // Wait phase: leaves after at least lat cycles once ready is seen
  task automatic wait_phase(input string tag, input logic [3:0] es, input int lat,
                            input logic ecp);
    int  k;
    logic done;
    k = 0;
    done = 1'b0;
    while (!done) begin
      ram_ready = (k >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
      done = (k >= lat - 1) && ram_ready;
      check_cycle(tag, es, idle(), ecp);
      k++;
    end
  endtask

  task automatic do_reset(input string tag);
    outs_t o;
    o = idle();
    o.clear_pc = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    assert (state === 4'd0) else begin
      errors++;
      $error("FAIL %s async state observed %0d expected 0", tag, state);
    end
    checks++;
    assert (obs === o) else begin
      errors++;
      $error("FAIL %s async outputs observed %h expected %h", tag, obs, o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cycle({tag, "_reset"}, 4'd0, o, cond_ref(cond, nzcv));
    o.clear_pc = 1'b0;
    o.load_pc = 1'b1;
    check_cycle({tag, "_load_pc"}, 4'd1, o, cond_ref(cond, nzcv));
  endtask

  // One instruction from FETCH to the following FETCH (or into HALT)
  task automatic run_instr(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                           input logic p, input logic u, input logic w);
    logic cp;
    outs_t o;
    opcode = op; cond = c; nzcv = f; P = p; U = u; W = w;
    cp = cond_ref(c, f);
    ram_ready = 1'($urandom_range(0, 1));
    check_cycle("fetch", 4'd2, idle(), cp);
    wait_phase("fetch_wait", 4'd3, FL, cp);
    ram_ready = 1'($urandom_range(0, 1));
    o = idle();
    o.load_ir = 1'b1;
    check_cycle("decode", 4'd4, o, cp);
    check_cycle("execute", 4'd5, cp ? exec_ref(op, c) : idle(), cp);
    if (cp && op == 7'd1) begin
      o = '0;
      o.halted = 1'b1;
      for (int i = 0; i < 20; i++) check_cycle("halt", 4'd9, o, cp);
      return;
    end
    if (cp) begin
      check_cycle("memory", 4'd6, mem_ref(op, c, p, u), cp);
      wait_phase("memory_wait", 4'd7, ML, cp);
    end
    ram_ready = 1'($urandom_range(0, 1));
    check_cycle("write_back", 4'd8, wb_ref(op, c, p, w, cp), cp);
  endtask

  initial begin
    #3;
    do_reset("init");
    run_instr(7'b0011000, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0011000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0011000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0011010, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b0);
    run_instr(7'b1110000, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b1100000, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b1);
    run_instr(7'b1001000, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_instr(7'b1111000, 4'b1010, 4'b1001, 1'b1, 1'b1, 1'b0);
    run_instr(7'b0000000, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0011000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0000001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(2, 127));
      run_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    // Reset landing mid-instruction, during the fetch wait
    opcode = 7'b0011000; cond = 4'b1110; nzcv = 4'b0000;
    ram_ready = 1'b0;
    check_cycle("pre_abort_fetch", 4'd2, idle(), 1'b1);
    do_reset("mid_instr");
    run_instr(7'b0011001, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(7'b0000001, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset("mid_halt");
    run_instr(7'b0011000, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
